// File: rtl/rosc_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rosc_sampler: samples a free-running ring oscillator into entropy words.     |
// | Build option: define VN_DEBIAS_EN for von Neumann pair debiasing.            |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module rosc_sampler #(
  parameter int SAMPLE_DIV  = 16,
  parameter int WORD_W      = 32,
  parameter int SEED_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              rosc_in,
  output logic              rosc_ctrl,
  output logic              rosc_seed,
  output logic [WORD_W-1:0] data,
  output logic              data_valid,
  input  logic              data_ack
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam logic [7:0]       c_div_last  = 8'(SAMPLE_DIV - 1);
  localparam logic [7:0]       c_div_one   = 8'd1;
  localparam logic [3:0]       c_seed_last = 4'(SEED_CYCLES - 1);
  localparam logic [3:0]       c_seed_one  = 4'd1;
  localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEED    = 2'd1,
    COLLECT = 2'd2,
    FULL    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_sync1;
  logic              r_sync2;
  logic [7:0]        r_div;
  logic [3:0]        r_seed_cnt;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [WORD_W-1:0] r_shift;
  logic              w_wrap;
  logic              w_stay_collect;
  logic              w_accept;
  logic              w_bit;
  logic              w_word_done;

  assign w_wrap         = (r_state == COLLECT) && (r_div == c_div_last);
  assign w_stay_collect = (r_state == COLLECT) && (w_state_nxt == COLLECT);

`ifdef VN_DEBIAS_EN
  logic r_pair_have;
  logic r_pair_a;

  // A bit is emitted only on the second sample of a pair that disagrees with the first.
  assign w_accept = w_wrap && r_pair_have && (r_pair_a != r_sync2);
  assign w_bit    = r_pair_a;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pair_have <= 1'b0;
      r_pair_a    <= 1'b0;
    end else if (w_stay_collect) begin
      if (w_wrap) begin
        r_pair_have <= ~r_pair_have;
        if (!r_pair_have) r_pair_a <= r_sync2;
      end
    end else begin
      r_pair_have <= 1'b0;
      r_pair_a    <= 1'b0;
    end
  end
`else
  assign w_accept = w_wrap;
  assign w_bit    = r_sync2;
`endif

  assign w_word_done = w_accept && (r_bit_cnt == c_cnt_last);
  assign rosc_ctrl   = (r_state == IDLE) || (r_state == SEED);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (enable) w_state_nxt = SEED;
      SEED:    if (r_seed_cnt == c_seed_last) w_state_nxt = COLLECT;
      COLLECT: if (w_word_done) w_state_nxt = FULL;
      FULL:    if (data_ack) w_state_nxt = COLLECT;
      default: w_state_nxt = IDLE;
    endcase
    if (!enable) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_div      <= '0;
      r_seed_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      rosc_seed  <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
    end else begin
      r_sync1    <= rosc_in;
      r_sync2    <= r_sync1;
      r_state    <= w_state_nxt;
      data_valid <= (w_state_nxt == FULL);

      if ((r_state == IDLE) && (w_state_nxt == SEED)) rosc_seed <= ~rosc_seed;

      if ((r_state == SEED) && (w_state_nxt == SEED)) r_seed_cnt <= r_seed_cnt + c_seed_one;
      else                                             r_seed_cnt <= '0;

      // Divider only runs while staying in COLLECT, so every entry restarts it at 0.
      if (w_stay_collect) r_div <= w_wrap ? '0 : r_div + c_div_one;
      else                r_div <= '0;

      if (w_word_done) data <= {r_shift[WORD_W-2:0], w_bit};

      if (!w_stay_collect) begin
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end else if (w_accept) begin
        r_bit_cnt <= r_bit_cnt + c_cnt_one;
        r_shift   <= {r_shift[WORD_W-2:0], w_bit};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rosc_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rosc_sampler: randomized self-checking bench with a sample-point model.  |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_rosc_sampler;

  localparam int DIV   = 16;
  localparam int W     = 32;
  localparam int SEEDC = 4;
  localparam int HMAX  = 32768;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         enable = 1'b0;
  logic         rosc_in = 1'b0;
  logic         data_ack = 1'b0;
  logic         rosc_ctrl;
  logic         rosc_seed;
  logic         data_valid;
  logic [W-1:0] data;

  rosc_sampler #(
    .SAMPLE_DIV (DIV),
    .WORD_W     (W),
    .SEED_CYCLES(SEEDC)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .rosc_in   (rosc_in),
    .rosc_ctrl (rosc_ctrl),
    .rosc_seed (rosc_seed),
    .data      (data),
    .data_valid(data_valid),
    .data_ack  (data_ack)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mode = 0;
  int   thr = 0;
  int   base = 0;
  logic exp_seed = 1'b0;
  logic in_hist [HMAX];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance one cycle; the value driven on rosc_in for cycle n is logged as in_hist[n].
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= HMAX) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, HMAX);
      $fatal(1, "cycle budget exhausted");
    end
    case (mode)
      0:       rosc_in = 1'b1;
      1:       rosc_in = 1'($urandom_range(0, 1));
      2:       rosc_in = (cyc < thr);
      default: rosc_in = ((((cyc - base) / DIV) % 2) == 1);
    endcase
    in_hist[cyc] = rosc_in;
  endtask

  // Sample point j of a COLLECT run entered in cycle e lies in cycle e+DIV*j-1 and sees the
  // oscillator value driven two cycles earlier. Returns the cycle data_valid should rise.
  function automatic void model_word(input int e, output int vcyc, output logic [W-1:0] w);
    int   n;
    int   c;
    logic s;
    logic a;
    bit   have;
    n = 0; a = 1'b0; have = 1'b0; w = '0; vcyc = -1;
    for (int j = 1; n < W && (e + DIV * j - 1) <= cyc; j++) begin
      c = e + DIV * j - 1;
      s = in_hist[c - 2];
`ifdef VN_DEBIAS_EN
      if (!have) begin
        a = s;
        have = 1'b1;
      end else begin
        have = 1'b0;
        if (a != s) begin
          w = {w[W-2:0], a};
          n++;
        end
      end
`else
      w = {w[W-2:0], s};
      n++;
`endif
      if (n == W) vcyc = c + 1;
    end
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_data"}, 64'(data), 64'd0);
    check_val({tag, "_valid"}, 64'(data_valid), 64'd0);
    check_val({tag, "_ctrl"}, 64'(rosc_ctrl), 64'd1);
    check_val({tag, "_seed"}, 64'(rosc_seed), 64'd0);
  endtask

  // Called in a cycle where the DUT is in IDLE; returns the COLLECT entry cycle.
  task automatic start_seq(output int e);
    enable = 1'b1;
    step();
    exp_seed = ~exp_seed;
    for (int k = 0; k < SEEDC; k++) begin
      check_val("seed_ctrl", 64'(rosc_ctrl), 64'd1);
      check_val("seed_val", 64'(rosc_seed), 64'(exp_seed));
      step();
    end
    check_val("collect_ctrl", 64'(rosc_ctrl), 64'd0);
    e = cyc;
  endtask

  task automatic wait_word(input int e, input string tag, output logic [W-1:0] w);
    int vc;
    int lim;
    lim = cyc + 8 * DIV * W;
    while (!data_valid && cyc < lim) begin
      data_ack = 1'($urandom_range(0, 1));
      step();
    end
    data_ack = 1'b0;
    model_word(e, vc, w);
    check_val({tag, "_valid"}, 64'(data_valid), 64'd1);
    check_val({tag, "_lat"}, 64'(cyc), 64'(vc));
    check_val({tag, "_data"}, 64'(data), 64'(w));
  endtask

  task automatic ack_word(input logic [W-1:0] prev, output int e);
    data_ack = 1'b1;
    step();
    data_ack = 1'b0;
    check_val("ack_valid", 64'(data_valid), 64'd0);
    check_val("ack_data_kept", 64'(data), 64'(prev));
    check_val("ack_ctrl", 64'(rosc_ctrl), 64'd0);
    e = cyc;
  endtask

  task automatic drop_with_ack();
    enable = 1'b0;
    data_ack = 1'b1;
    step();
    data_ack = 1'b0;
    check_val("drop_valid", 64'(data_valid), 64'd0);
    check_val("drop_ctrl", 64'(rosc_ctrl), 64'd1);
    step();
    check_val("idle_ctrl", 64'(rosc_ctrl), 64'd1);
    check_val("idle_seed", 64'(rosc_seed), 64'(exp_seed));
  endtask

  initial begin
    int           e;
    logic [W-1:0] w;
    bit           saw_valid;

    reset_n = 1'b0;
    enable  = 1'b1;
    mode    = 0;
    for (int k = 0; k < 2; k++) begin
      step();
      check_reset_outputs("reset");
    end
    reset_n = 1'b1;
    start_seq(e);

`ifndef VN_DEBIAS_EN
    wait_word(e, "const1", w);
    check_val("const1_word", 64'(data), 64'hFFFF_FFFF);
    check_val("const1_latency", 64'(cyc - e), 64'(W * DIV));
    for (int k = 0; k < 1000; k++) begin
      step();
      check_val("hold_data", 64'(data), 64'hFFFF_FFFF);
      check_val("hold_valid", 64'(data_valid), 64'd1);
      check_val("hold_ctrl", 64'(rosc_ctrl), 64'd0);
    end
    ack_word(w, e);
    mode = 2;
    thr  = e + DIV * 16 - 2;
    wait_word(e, "step16", w);
    check_val("step16_word", 64'(data), 64'hFFFF_0000);
    check_val("step16_latency", 64'(cyc - e), 64'(W * DIV));
`else
    saw_valid = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      step();
      if (data_valid) saw_valid = 1'b1;
    end
    check_val("const1_never_valid", 64'(saw_valid), 64'd0);
    enable = 1'b0;
    step();
    check_val("const1_idle_ctrl", 64'(rosc_ctrl), 64'd1);
    start_seq(e);
    mode = 3;
    base = e - 3;
    wait_word(e, "alt", w);
    check_val("alt_word", 64'(data), 64'hFFFF_FFFF);
    check_val("alt_latency", 64'(cyc - e), 64'(2 * W * DIV));
`endif

    // enable low wins over a simultaneous ack in FULL
    drop_with_ack();

    mode = 1;
    start_seq(e);
    wait_word(e, "rand_a", w);
    ack_word(w, e);
    wait_word(e, "rand_b", w);
    ack_word(w, e);

    // abandon a partial word after ten sample points
    while (cyc < e + 10 * DIV + 2) begin
      data_ack = 1'($urandom_range(0, 1));
      step();
    end
    data_ack = 1'b0;
    enable = 1'b0;
    step();
    check_val("abort_ctrl", 64'(rosc_ctrl), 64'd1);
    check_val("abort_valid", 64'(data_valid), 64'd0);
    for (int k = 0; k < 3; k++) step();
    start_seq(e);
    wait_word(e, "restart", w);

    // reset in the middle of collection
    ack_word(w, e);
    for (int k = 0; k < 100; k++) step();
    reset_n = 1'b0;
    exp_seed = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      check_reset_outputs("midreset");
    end
    reset_n = 1'b1;
    start_seq(e);
    wait_word(e, "post_reset", w);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rosc_sampler.md
ROSC_SAMPLER -- requirements
Module: rosc_sampler

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 16: clk cycles between samples, legal 2..255.
REQ-002 SHALL have parameter WORD_W, default 32: output word width, legal 8..64.
REQ-003 SHALL have parameter SEED_CYCLES, default 4: cycles the oscillator is held in seed mode, legal 1..15.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 enable  input  1  level; high = run oscillator and collect bits.
REQ-007 rosc_in  input  1  oscillator output, asynchronous to clk.
REQ-008 rosc_ctrl  output  1  oscillator control; 1 = seed/hold, 0 = free-run.
REQ-009 rosc_seed  output  1  seed value for the oscillator.
REQ-010 data  output  WORD_W  collected entropy word.
REQ-011 data_valid  output  1  data holds a complete word.
REQ-012 data_ack  input  1  consumer accepts data.

Function
REQ-013 SHALL pass rosc_in through a two-flop synchronizer; only the second flop output (sync bit) is used.
REQ-014 SHALL implement states IDLE, SEED, COLLECT, FULL.
REQ-015 IDLE: rosc_ctrl=1, data_valid=0, divider and bit count held at 0; enable=1 -> SEED.
REQ-016 On entry to SEED, rosc_seed SHALL toggle; SEED holds rosc_ctrl=1 for exactly SEED_CYCLES cycles, then -> COLLECT.
REQ-017 COLLECT: rosc_ctrl=0; divider reset to 0 on entry, increments each cycle, wraps at SAMPLE_DIV-1, and a sample is taken of the sync bit in the wrap cycle.
REQ-018 Each accepted bit SHALL shift into the shift register at LSB (shift left); the first bit ends in data MSB.
REQ-019 When the WORD_W-th bit is accepted, data SHALL load the shift register and data_valid SHALL go high the next cycle; state -> FULL.
REQ-020 Latency, debias off: data_valid high exactly WORD_W*SAMPLE_DIV cycles after COLLECT entry.
REQ-021 FULL: rosc_ctrl=0, divider halted, data and data_valid stable until data_ack=1.
REQ-022 data_ack=1 in FULL SHALL clear data_valid the next cycle, clear bit count, -> COLLECT (divider restarts from 0); data retains its value.
REQ-023 data_ack outside FULL SHALL be ignored.
REQ-024 enable=0 in any state SHALL force IDLE next cycle, clear data_valid, discard partial bits; enable=0 overrides a simultaneous data_ack.
REQ-025 rosc_seed SHALL change only on SEED entry.

Reset
REQ-026 reset_n=0 at a clock edge SHALL give: state IDLE, data=0, data_valid=0, rosc_ctrl=1, rosc_seed=0, synchronizer, divider, bit count, shift register=0.
REQ-027 Reset mid-operation SHALL discard any partial or pending word; no data_valid until a complete new word.

Configuration
REQ-028 Macro VN_DEBIAS_EN defined: samples SHALL be taken in pairs (a,b); a!=b accepts bit a, a==b discards both; pair state cleared on leaving COLLECT.
REQ-029 VN_DEBIAS_EN undefined: every sample SHALL be accepted as one bit; no pairing logic present.

Verification
REQ-030 reset_n=0 two cycles, enable=1 -> data=0, data_valid=0, rosc_ctrl=1, rosc_seed=0 throughout reset.
REQ-031 Debias off, defaults, rosc_in=1 constant, enable=1 -> rosc_seed=1, rosc_ctrl=1 for 4 cycles, data_valid at COLLECT entry +512 cycles, data=0xFFFFFFFF.
REQ-032 Debias off, rosc_in=1 for first 16 sample points then 0 (2-cycle sync delay accounted) -> data=0xFFFF0000.
REQ-033 data_ack held 0 for 1000 cycles after valid -> data/data_valid stable, rosc_ctrl=0; one-cycle ack -> data_valid=0 next cycle, next word after 512 cycles.
REQ-034 enable dropped after 10 samples, re-raised -> IDLE next cycle, rosc_ctrl=1, rosc_seed toggles back to 0 on re-entry, next word contains only post-restart samples.
REQ-035 VN_DEBIAS_EN, rosc_in=1 constant -> data_valid never asserts; alternating 1,0 per sample point -> data=0xFFFFFFFF after 1024 cycles.
